// File: rtl/sub16_serial.sv
// rtl/sub16_serial.sv - bit-serial WIDTH-bit subtractor (a - b - bin) with start/busy/done handshake.
// Optional build macro SUB16_SERIAL_RADIX4_EN: two bits per BUSY cycle instead of one.
module sub16_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

`ifdef SUB16_SERIAL_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int NSTEPS = WIDTH / STEP;
  localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             d0;
  logic             b1;
  logic [WIDTH-1:0] r_next;
  logic             brw_next;

`ifdef SUB16_SERIAL_RADIX4_EN
  logic             d1;
  logic             b2;
  logic [WIDTH+1:0] r_cat;

  // Second borrow stage chained directly off the first within the same cycle.
  always_comb begin
    d0       = a_sh[0] ^ b_sh[0] ^ brw;
    b1       = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
    d1       = a_sh[1] ^ b_sh[1] ^ b1;
    b2       = (~a_sh[1] & b_sh[1]) | (~(a_sh[1] ^ b_sh[1]) & b1);
    r_cat    = {d1, d0, r_sh};
    r_next   = r_cat[WIDTH+1:2];
    brw_next = b2;
  end
`else
  logic [WIDTH:0]   r_cat;

  always_comb begin
    d0       = a_sh[0] ^ b_sh[0] ^ brw;
    b1       = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
    r_cat    = {d0, r_sh};
    r_next   = r_cat[WIDTH:1];
    brw_next = b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            r_sh  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        BUSY: begin
          a_sh <= a_sh >> STEP;
          b_sh <= b_sh >> STEP;
          r_sh <= r_next;
          brw  <= brw_next;
          cnt  <= cnt + CW'(1);
          // Outputs update only here so partial shift values never leak out.
          if (cnt == CW'(NSTEPS - 1)) begin
            diff  <= r_next;
            bout  <= brw_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
